// File: rtl/dino_game_ctrl_if.sv
// Signal bundle between the dino game controller and its frame-level neighbours:
// button, obstacle/player boxes in; game state, score and generator control out.
interface dino_game_ctrl_if;
    logic        start;
    logic [9:0]  obs_x;
    logic [8:0]  obs_y;
    logic [9:0]  obs_w;
    logic [8:0]  obs_h;
    logic [9:0]  dino_x;
    logic [8:0]  dino_y;
    logic [9:0]  dino_w;
    logic [8:0]  dino_h;
    logic [1:0]  game_state;
    logic        obs_rst;
    logic        stop;
    logic        hit;
    logic [15:0] score;
    logic [15:0] hiscore;
    logic [1:0]  speed_lvl;

    modport master (
        output start, obs_x, obs_y, obs_w, obs_h, dino_x, dino_y, dino_w, dino_h,
        input  game_state, obs_rst, stop, hit, score, hiscore, speed_lvl
    );

    modport slave (
        input  start, obs_x, obs_y, obs_w, obs_h, dino_x, dino_y, dino_w, dino_h,
        output game_state, obs_rst, stop, hit, score, hiscore, speed_lvl
    );
endinterface

// File: rtl/dino_game_ctrl.sv
// Dino game controller: IDLE/RUN/OVER FSM, box overlap test, BCD score and speed level.
// Define DINO_HISCORE_EN to build the high-score register (otherwise hiscore is 0).
module dino_game_ctrl #(
    parameter int unsigned SCORE_DIV = 4,
    parameter logic [15:0] LVL_STEP  = 16'h0100,
    parameter int unsigned OVER_HOLD = 25
) (
    input  logic             clk_25Hz,
    input  logic             rst,
    dino_game_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StOver = 2'b10
    } state_e;

    localparam logic [7:0] DivLast  = 8'(SCORE_DIV - 1);
    localparam logic [7:0] HoldLast = 8'(OVER_HOLD);

    state_e      state_q, state_d;
    logic        start_q, start_d;
    logic        obs_rst_q, obs_rst_d;
    logic        stop_q, stop_d;
    logic        hit_q, hit_d;
    logic [15:0] score_q, score_d;
    logic [15:0] lvl_cnt_q, lvl_cnt_d;
    logic [1:0]  speed_q, speed_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  hold_q, hold_d;

    logic        start_rise;
    logic        restart;
    logic        overlap;
    logic [10:0] dino_xr, obs_xr;
    logic [9:0]  dino_yb, obs_yb;
    logic [15:0] score_inc, lvl_inc;

    // Increment of a 4-digit packed BCD value; 9999 wraps, callers saturate.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Widened sums so right/bottom edges never wrap.
    assign dino_xr = {1'b0, bus.dino_x} + {1'b0, bus.dino_w};
    assign obs_xr  = {1'b0, bus.obs_x} + {1'b0, bus.obs_w};
    assign dino_yb = {1'b0, bus.dino_y} + {1'b0, bus.dino_h};
    assign obs_yb  = {1'b0, bus.obs_y} + {1'b0, bus.obs_h};

    assign overlap = (bus.obs_h != 9'd0)
                  && ({1'b0, bus.obs_x} < dino_xr)
                  && ({1'b0, bus.dino_x} < obs_xr)
                  && ({1'b0, bus.obs_y} < dino_yb)
                  && ({1'b0, bus.dino_y} < obs_yb);

    assign start_rise = bus.start & ~start_q;
    assign score_inc  = bcd_inc(score_q);
    assign lvl_inc    = bcd_inc(lvl_cnt_q);

    always_comb begin
        state_d   = state_q;
        start_d   = bus.start;
        obs_rst_d = 1'b0;
        hit_d     = hit_q;
        score_d   = score_q;
        lvl_cnt_d = lvl_cnt_q;
        speed_d   = speed_q;
        div_d     = div_q;
        hold_d    = hold_q;
        restart   = 1'b0;

        unique case (state_q)
            StIdle: begin
                restart = start_rise;
            end
            StRun: begin
                if (overlap) begin
                    state_d = StOver;
                    hit_d   = 1'b1;
                    hold_d  = 8'd0;
                end else if (div_q == DivLast) begin
                    div_d = 8'd0;
                    if (score_q != 16'h9999) begin
                        score_d = score_inc;
                        // lvl_cnt tracks points since the last level change, in BCD
                        if (lvl_inc == LVL_STEP) begin
                            lvl_cnt_d = 16'h0000;
                            if (speed_q != 2'd3) speed_d = speed_q + 2'd1;
                        end else begin
                            lvl_cnt_d = lvl_inc;
                        end
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            StOver: begin
                if (hold_q < HoldLast) begin
                    hold_d = hold_q + 8'd1;
                end else begin
                    restart = start_rise;
                end
            end
            default: state_d = StIdle;
        endcase

        if (restart) begin
            state_d   = StRun;
            obs_rst_d = 1'b1;
            hit_d     = 1'b0;
            score_d   = 16'h0000;
            lvl_cnt_d = 16'h0000;
            speed_d   = 2'd0;
            div_d     = 8'd0;
        end

        stop_d = (state_d != StRun);
    end

    always_ff @(posedge clk_25Hz) begin
        if (rst) begin
            state_q   <= StIdle;
            start_q   <= 1'b1;
            obs_rst_q <= 1'b0;
            stop_q    <= 1'b1;
            hit_q     <= 1'b0;
            score_q   <= 16'h0000;
            lvl_cnt_q <= 16'h0000;
            speed_q   <= 2'd0;
            div_q     <= 8'd0;
            hold_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            obs_rst_q <= obs_rst_d;
            stop_q    <= stop_d;
            hit_q     <= hit_d;
            score_q   <= score_d;
            lvl_cnt_q <= lvl_cnt_d;
            speed_q   <= speed_d;
            div_q     <= div_d;
            hold_q    <= hold_d;
        end
    end

`ifdef DINO_HISCORE_EN
    // Power-up value only; reset deliberately leaves the high score alone.
    logic [15:0] hiscore_q = 16'h0000;
    logic [15:0] hiscore_d;

    always_comb begin
        hiscore_d = hiscore_q;
        if ((state_q == StRun) && (state_d == StOver) && (score_q > hiscore_q)) begin
            hiscore_d = score_q;
        end
    end

    always_ff @(posedge clk_25Hz) begin
        if (!rst) hiscore_q <= hiscore_d;
    end

    assign bus.hiscore = hiscore_q;
`else
    assign bus.hiscore = 16'h0000;
`endif

    assign bus.game_state = state_q;
    assign bus.obs_rst    = obs_rst_q;
    assign bus.stop       = stop_q;
    assign bus.hit        = hit_q;
    assign bus.score      = score_q;
    assign bus.speed_lvl  = speed_q;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Directed bench for dino_game_ctrl: reset/start, scoring, collision edges,
// restart hold-off, high score and score saturation.
module tb_dino_game_ctrl;

    logic clk_25Hz = 1'b0;
    logic rst      = 1'b1;
    int   checks   = 0;
    int   errors   = 0;

`ifdef DINO_HISCORE_EN
    localparam logic [15:0] Hi1 = 16'h0123;
`else
    localparam logic [15:0] Hi1 = 16'h0000;
`endif

    dino_game_ctrl_if bus ();

    dino_game_ctrl #(
        .SCORE_DIV (4),
        .LVL_STEP  (16'h0100),
        .OVER_HOLD (25)
    ) dut (
        .clk_25Hz (clk_25Hz),
        .rst      (rst),
        .bus      (bus)
    );

    always #20 clk_25Hz = ~clk_25Hz;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_25Hz);
            #1;
        end
    endtask

    task automatic set_obs(input logic [9:0] x, input logic [8:0] y,
                           input logic [9:0] w, input logic [8:0] h);
        bus.obs_x = x;
        bus.obs_y = y;
        bus.obs_w = w;
        bus.obs_h = h;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        tick(2);
        if (bus.game_state !== 2'b00) begin errors++; $display("FAIL rst_state: got %b expected 00", bus.game_state); end
        checks++;
        if (bus.stop !== 1'b1) begin errors++; $display("FAIL rst_stop: got %b expected 1", bus.stop); end
        checks++;
        if (bus.obs_rst !== 1'b0) begin errors++; $display("FAIL rst_obs_rst: got %b expected 0", bus.obs_rst); end
        checks++;
        if (bus.hit !== 1'b0) begin errors++; $display("FAIL rst_hit: got %b expected 0", bus.hit); end
        checks++;
        chk("rst_score", bus.score, 16'h0000);
        chk("rst_speed", {14'd0, bus.speed_lvl}, 16'd0);
        chk("rst_hiscore", bus.hiscore, 16'h0000);
        rst = 1'b0;
        tick(3);
        chk("held_start_state", {14'd0, bus.game_state}, 16'd0);
        chk("held_start_stop", {15'd0, bus.stop}, 16'd1);
    endtask

    task automatic test_start();
        bus.start = 1'b0;
        tick(1);
        bus.start = 1'b1;
        tick(1);
        chk("start_state", {14'd0, bus.game_state}, 16'd1);
        chk("start_obs_rst", {15'd0, bus.obs_rst}, 16'd1);
        chk("start_stop", {15'd0, bus.stop}, 16'd0);
        tick(1);
        chk("start_obs_rst_end", {15'd0, bus.obs_rst}, 16'd0);
        chk("start_still_run", {14'd0, bus.game_state}, 16'd1);
    endtask

    // Entered RUN at edge E0; now at E1.
    task automatic test_scoring();
        tick(2);
        chk("score_e3", bus.score, 16'h0000);
        tick(1);
        chk("score_first_point", bus.score, 16'h0001);
        tick(395);
        chk("score_e399", bus.score, 16'h0099);
        chk("speed_e399", {14'd0, bus.speed_lvl}, 16'd0);
        tick(1);
        chk("score_e400", bus.score, 16'h0100);
        chk("speed_e400", {14'd0, bus.speed_lvl}, 16'd1);
    endtask

    task automatic test_collision();
        set_obs(10'd70, 9'd365, 10'd17, 9'd35);
        tick(1);
        chk("x_touch_hit", {15'd0, bus.hit}, 16'd0);
        chk("x_touch_state", {14'd0, bus.game_state}, 16'd1);
        set_obs(10'd55, 9'd360, 10'd1, 9'd0);
        tick(1);
        chk("no_obs_hit", {15'd0, bus.hit}, 16'd0);
        chk("no_obs_state", {14'd0, bus.game_state}, 16'd1);
        set_obs(10'd60, 9'd400, 10'd10, 9'd20);
        tick(1);
        chk("y_touch_hit", {15'd0, bus.hit}, 16'd0);
        // Edge E404 would add a point, but the hit wins.
        set_obs(10'd69, 9'd365, 10'd17, 9'd35);
        tick(1);
        chk("coll_state", {14'd0, bus.game_state}, 16'd2);
        chk("coll_hit", {15'd0, bus.hit}, 16'd1);
        chk("coll_stop", {15'd0, bus.stop}, 16'd1);
        chk("coll_score", bus.score, 16'h0100);
        tick(4);
        chk("over_score_frozen", bus.score, 16'h0100);
        chk("over_state_hold", {14'd0, bus.game_state}, 16'd2);
    endtask

    // Hit edge is frame 0; now at frame 4, obstacle still overlapping.
    task automatic test_restart();
        bus.start = 1'b0;
        tick(5);
        bus.start = 1'b1;
        tick(1);
        chk("early_start_state", {14'd0, bus.game_state}, 16'd2);
        chk("early_start_hit", {15'd0, bus.hit}, 16'd1);
        chk("early_start_obs_rst", {15'd0, bus.obs_rst}, 16'd0);
        bus.start = 1'b0;
        tick(15);
        bus.start = 1'b1;
        tick(1);
        chk("restart_state", {14'd0, bus.game_state}, 16'd1);
        chk("restart_score", bus.score, 16'h0000);
        chk("restart_hit", {15'd0, bus.hit}, 16'd0);
        chk("restart_obs_rst", {15'd0, bus.obs_rst}, 16'd1);
        chk("restart_speed", {14'd0, bus.speed_lvl}, 16'd0);
        set_obs(10'd69, 9'd365, 10'd17, 9'd0);
        tick(1);
        chk("restart_obs_rst_end", {15'd0, bus.obs_rst}, 16'd0);
        chk("restart_run", {14'd0, bus.game_state}, 16'd1);
    endtask

    // Game 1 began at R0; now at R1.
    task automatic test_hiscore();
        tick(491);
        chk("game1_score", bus.score, 16'h0123);
        set_obs(10'd69, 9'd365, 10'd17, 9'd35);
        tick(1);
        chk("game1_over", {14'd0, bus.game_state}, 16'd2);
        chk("game1_hiscore", bus.hiscore, Hi1);
        set_obs(10'd69, 9'd365, 10'd17, 9'd0);
        bus.start = 1'b0;
        tick(26);
        bus.start = 1'b1;
        tick(1);
        chk("game2_start", {14'd0, bus.game_state}, 16'd1);
        tick(180);
        chk("game2_score", bus.score, 16'h0045);
        set_obs(10'd69, 9'd365, 10'd17, 9'd35);
        tick(1);
        chk("game2_over", {14'd0, bus.game_state}, 16'd2);
        chk("game2_hiscore", bus.hiscore, Hi1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_mid_state", {14'd0, bus.game_state}, 16'd0);
        chk("rst_mid_hit", {15'd0, bus.hit}, 16'd0);
        chk("rst_mid_score", bus.score, 16'h0000);
        chk("rst_mid_hiscore", bus.hiscore, Hi1);
    endtask

    task automatic test_saturation();
        set_obs(10'd69, 9'd365, 10'd17, 9'd0);
        bus.start = 1'b0;
        tick(1);
        bus.start = 1'b1;
        tick(1);
        chk("sat_start", {14'd0, bus.game_state}, 16'd1);
        tick(39995);
        chk("sat_9998", bus.score, 16'h9998);
        chk("sat_speed", {14'd0, bus.speed_lvl}, 16'd3);
        tick(1);
        chk("sat_9999", bus.score, 16'h9999);
        tick(8);
        chk("sat_hold", bus.score, 16'h9999);
        chk("sat_run", {14'd0, bus.game_state}, 16'd1);
    endtask

    initial begin
        bus.start  = 1'b1;
        bus.dino_x = 10'd50;
        bus.dino_y = 9'd350;
        bus.dino_w = 10'd20;
        bus.dino_h = 9'd50;
        set_obs(10'd0, 9'd0, 10'd0, 9'd0);
        #5;
        test_reset();
        test_start();
        test_scoring();
        test_collision();
        test_restart();
        test_hiscore();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dino_game_ctrl.md
# dino_game_ctrl

Game-level controller downstream of the obstacle generator. Each 25 Hz frame it takes the obstacle bounding box and the player bounding box, and tests whether they overlap. It runs the IDLE/RUN/OVER game state machine and drives the obstacle generator's `rst` and `stop` inputs. It also keeps a 4-digit BCD score and a speed level for the display and scroll logic.

## Interface
- `SCORE_DIV`, 4, frames per score point (2..255)
- `LVL_STEP`, 16'h0100, BCD score increment between speed levels
- `OVER_HOLD`, 25, minimum frames in OVER before a restart is accepted (1..255)
- `clk_25Hz` in 1: frame clock
- `rst` in 1: synchronous, active-high
- `start` in 1: start/jump button level, already synchronised
- `obs_x` in 10: obstacle left edge
- `obs_y` in 9: obstacle top edge
- `obs_w` in 10: obstacle width
- `obs_h` in 9: obstacle height; 0 means no obstacle
- `dino_x` in 10, `dino_y` in 9: player top-left corner
- `dino_w` in 10, `dino_h` in 9: player size
- `game_state` out 2: 00 IDLE, 01 RUN, 10 OVER
- `obs_rst` out 1: one-frame pulse that resets the obstacle generator
- `stop` out 1: level, high in IDLE and OVER
- `hit` out 1: registered overlap flag
- `score` out 16: 4 BCD digits
- `hiscore` out 16: 4 BCD digits
- `speed_lvl` out 2: 0..3

## Operation
- **Overlap test.** Overlap is true when all of the following hold:
  - `obs_h != 0`
  - `obs_x < dino_x+dino_w`
  - `dino_x < obs_x+obs_w`
  - `obs_y < dino_y+dino_h`
  - `dino_y < obs_y+obs_h`
  - Sums are computed at 11 bits (x) and 10 bits (y), so there is no wrap.
  - Edges that only touch do not count as overlap.
- **Start edge.** `start_rise = start & ~start_q`, where `start_q` is the previous-frame sample.
- **IDLE.**
  - `stop`=1.
  - On `start_rise`: go to RUN, pulse `obs_rst`, clear `score`, the frame divider and `speed_lvl`.
- **RUN.**
  - `stop`=0.
  - The divider counts 0..SCORE_DIV-1. On wrap, `score` increments as BCD with per-digit carry and saturates at 9999.
  - `hit` = registered overlap. On the edge where overlap is true: go to OVER, set `hit`=1, and do not increment the score on that edge.
- **Speed level.**
  - `speed_lvl` increments, saturating at 3, each time a score increment crosses a multiple of `LVL_STEP`.
  - Default thresholds: 100, 200, 300.
- **OVER.**
  - `stop`=1 and `hit` stays 1. The score is frozen.
  - A hold counter counts up to OVER_HOLD. `start_rise` is ignored until the count is reached.
  - After that, `start_rise` acts exactly as in IDLE, and `hit` clears.
- **Simultaneous events.** `rst` beats everything. Overlap in the same frame as the IDLE→RUN transition is ignored, because overlap is only evaluated while already in RUN.

## Timing
- **Reset values:**
  - `game_state`=IDLE, `stop`=1, `obs_rst`=0, `hit`=0
  - `score`=0, `speed_lvl`=0, `start_q`=1 (a button held through reset does not start a game)
  - `hiscore`=0
- **Reset mid-game.** `rst` during RUN or OVER returns to IDLE on the next edge; `hiscore` is preserved.
- **Start latency.** `obs_rst` goes high on the edge after `start` rises and lasts exactly one frame (40 ms). This is long enough for the 25 MHz-sampled generator to catch it. `stop` falls on the same edge.
- **Collision latency.** The collision is registered: `hit`, `stop`=1 and OVER all appear on the first edge where the inputs overlap.
- **Scoring rate.** The first point arrives SCORE_DIV edges after entering RUN.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `DINO_HISCORE_EN` defined:
  - On every RUN→OVER transition, `hiscore` loads `score` if `score > hiscore`. Packed BCD compares correctly as unsigned.
  - `hiscore` is preserved by `rst`, and clears only when the bitstream is configured.
- `DINO_HISCORE_EN` undefined: `hiscore` is constant 16'h0000 and no compare logic is built.

## Test plan
- **Reset, then start.**
  - Stimulus: assert `rst`, release it, then hold `start`=1 with no edge.
  - Required: the block stays in IDLE with `stop`=1.
  - Stimulus: drop `start` to 0, then raise it to 1.
  - Required: the next edge gives RUN, `obs_rst`=1 for exactly one frame, `stop`=0.
- **Scoring.**
  - Stimulus: remain in RUN for 400 frames with `obs_h`=0 (SCORE_DIV=4).
  - Required: `score`=16'h0100 and `speed_lvl`=1.
  - Stimulus: preload `score` to 9999.
  - Required: it stays at 9999.
- **Collision.**
  - Stimulus: dino (50,350,20,50) and obstacle (69,365,17,35).
  - Required: on the next edge, OVER, `hit`=1, `stop`=1, and the score frozen.
  - Stimulus: obstacle at x=70 instead.
  - Required: no hit (edges touch only).
- **No-obstacle case.**
  - Stimulus: obstacle fully overlapping the dino but `obs_h`=0, `obs_w`=1.
  - Required: no hit.
- **Restart hold-off.**
  - Stimulus: in OVER, a `start` edge at frame 10 after the hit.
  - Required: ignored.
  - Stimulus: a `start` edge at frame 26.
  - Required: RUN, `score`=0, `hit`=0, one `obs_rst` pulse.
- **High score (with `DINO_HISCORE_EN`).**
  - Stimulus: game 1 ends at 0123, game 2 ends at 0045.
  - Required: `hiscore`=0123 after both games.
  - Stimulus: `rst`.
  - Required: `hiscore` is still 0123.
